reset_manager: RTL

RESET_MANAGER -- requirements
Module: reset_manager

---
 rtl/reset_manager_pkg.sv | 26 ++
 rtl/reset_manager_sync_cell.sv | 27 ++
 rtl/reset_manager.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/reset_manager_pkg.sv
// Shared definitions for the reset manager: state encoding and counter sizing.
package reset_manager_pkg;

   // Fixed encoding presented on state_o.
   localparam logic [2:0] STATE_WAIT_LOCK = 3'd0;
   localparam logic [2:0] STATE_STABLE    = 3'd1;
   localparam logic [2:0] STATE_RELEASE   = 3'd2;
   localparam logic [2:0] STATE_RUN       = 3'd3;
   localparam logic [2:0] STATE_SW_HOLD   = 3'd4;

   typedef enum logic [2:0] {
      ST_WAIT_LOCK = STATE_WAIT_LOCK,
      ST_STABLE    = STATE_STABLE,
      ST_RELEASE   = STATE_RELEASE,
      ST_RUN       = STATE_RUN,
      ST_SW_HOLD   = STATE_SW_HOLD
   } state_e;

   // Largest of three counts; used to size the shared cycle counter.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/reset_manager_sync_cell.sv
// sync_cell: STAGES-deep flop chain bringing an asynchronous level into clk,
// cleared to 0 by the asynchronous reset.
module sync_cell #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   // Shift the input through the synchroniser chain.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's old value, so the chain really is STAGES flops deep.
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/reset_manager.sv
// reset_manager: qualifies PLL lock, then releases N_DOMAINS active-low
// resets in order, one every STAGE_GAP_CYCLES. Supports a software reset
// request while running.
// Optional feature: define RESET_MANAGER_LOCK_RECOVERY_EN to make a lock
// drop while running pull all resets low, set lock_lost and requalify.
// Without it, lock drops in RUN are ignored and lock_lost stays 0.
module reset_manager
   import reset_manager_pkg::*;
#(
   parameter int N_DOMAINS          = 3,
   parameter int SYNC_STAGES        = 2,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int STAGE_GAP_CYCLES   = 16,
   parameter int SW_HOLD_CYCLES     = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 pll_lock,
   input  logic                 sw_rst_req,
   output logic [N_DOMAINS-1:0] rst_n_out,
   output logic                 ready,
   output logic                 lock_lost,
   output logic [2:0]           state_o
);

   localparam int CNT_MAX = max3(LOCK_STABLE_CYCLES, STAGE_GAP_CYCLES * N_DOMAINS,
                                 SW_HOLD_CYCLES);
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;

   localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]     LOCK_TGT  = CNT_W'(LOCK_STABLE_CYCLES);
   localparam logic [CNT_W-1:0]     GAP_TGT   = CNT_W'(STAGE_GAP_CYCLES);
   localparam logic [CNT_W-1:0]     HOLD_TGT  = CNT_W'(SW_HOLD_CYCLES);
   localparam logic [N_DOMAINS-1:0] REL_FIRST = N_DOMAINS'(1);

   // Parameter lower bounds, checked at elaboration.
   if (N_DOMAINS < 1) begin : g_chk_domains
      $error("reset_manager: N_DOMAINS must be >= 1");
   end
   if (SYNC_STAGES < 2) begin : g_chk_sync
      $error("reset_manager: SYNC_STAGES must be >= 2");
   end
   if (LOCK_STABLE_CYCLES < 1) begin : g_chk_lock
      $error("reset_manager: LOCK_STABLE_CYCLES must be >= 1");
   end
   if (STAGE_GAP_CYCLES < 1) begin : g_chk_gap
      $error("reset_manager: STAGE_GAP_CYCLES must be >= 1");
   end
   if (SW_HOLD_CYCLES < 1) begin : g_chk_hold
      $error("reset_manager: SW_HOLD_CYCLES must be >= 1");
   end

   logic                 lock_sync;
   state_e               state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [CNT_W-1:0]     cnt_inc;
   logic [N_DOMAINS-1:0] rst_n_out_q;
   logic [N_DOMAINS-1:0] rel_next;
   logic                 ready_q;
   logic                 lock_lost_q;

   // pll_lock is only ever observed through this synchroniser.
   sync_cell #(
      .STAGES (SYNC_STAGES)
   ) u_lock_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (pll_lock),
      .q_o   (lock_sync)
   );

   assign cnt_inc  = cnt_q + CNT_ONE;
   // Releasing the next domain extends the run of ones up from bit 0.
   assign rel_next = (rst_n_out_q << 1) | REL_FIRST;

   // Sequencer FSM with registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_WAIT_LOCK;
         cnt_q       <= '0;
         rst_n_out_q <= '0;
         ready_q     <= 1'b0;
         lock_lost_q <= 1'b0;
      end else begin
         unique case (state_q)
            ST_WAIT_LOCK: begin
               rst_n_out_q <= '0;
               ready_q     <= 1'b0;
               cnt_q       <= '0;
               if (lock_sync) begin
                  state_q <= ST_STABLE;
               end
            end

            ST_STABLE: begin
               if (!lock_sync) begin
                  state_q     <= ST_WAIT_LOCK;
                  cnt_q       <= '0;
                  rst_n_out_q <= '0;
               end else if (cnt_inc == LOCK_TGT) begin
                  cnt_q       <= '0;
                  rst_n_out_q <= REL_FIRST;
                  if (REL_FIRST[N_DOMAINS-1]) begin
                     state_q <= ST_RUN;
                     ready_q <= 1'b1;
                  end else begin
                     state_q <= ST_RELEASE;
                  end
               end else begin
                  cnt_q <= cnt_inc;
               end
            end

            ST_RELEASE: begin
               if (!lock_sync) begin
                  state_q     <= ST_WAIT_LOCK;
                  cnt_q       <= '0;
                  rst_n_out_q <= '0;
               end else if (cnt_inc == GAP_TGT) begin
                  cnt_q       <= '0;
                  rst_n_out_q <= rel_next;
                  if (rel_next[N_DOMAINS-1]) begin
                     state_q <= ST_RUN;
                     ready_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_inc;
               end
            end

            ST_RUN: begin
`ifdef RESET_MANAGER_LOCK_RECOVERY_EN
               if (!lock_sync) begin
                  state_q     <= ST_WAIT_LOCK;
                  cnt_q       <= '0;
                  rst_n_out_q <= '0;
                  ready_q     <= 1'b0;
                  lock_lost_q <= 1'b1;
               end else if (sw_rst_req) begin
                  state_q     <= ST_SW_HOLD;
                  cnt_q       <= '0;
                  rst_n_out_q <= '0;
                  ready_q     <= 1'b0;
                  lock_lost_q <= 1'b0;
               end
`else
               if (sw_rst_req) begin
                  state_q     <= ST_SW_HOLD;
                  cnt_q       <= '0;
                  rst_n_out_q <= '0;
                  ready_q     <= 1'b0;
                  lock_lost_q <= 1'b0;
               end
`endif
            end

            ST_SW_HOLD: begin
               if (cnt_inc == HOLD_TGT) begin
                  state_q <= ST_WAIT_LOCK;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end

            default: begin
               state_q     <= ST_WAIT_LOCK;
               cnt_q       <= '0;
               rst_n_out_q <= '0;
               ready_q     <= 1'b0;
            end
         endcase
      end
   end

   assign rst_n_out = rst_n_out_q;
   assign ready     = ready_q;
   assign lock_lost = lock_lost_q;
   assign state_o   = state_q;

endmodule
